// File: rtl/core_pipe_exec_lsu.sv
// core_pipe_exec_lsu: execute-stage load/store controller.
// Issues one outstanding access at a time on the dmem bus and returns
// extended load data for writeback. It also flags misaligned accesses and
// bus errors.
// Optional build macro LSU_REQ_TIMEOUT_EN adds a grant timeout that ends a
// stuck request as a bus error after TIMEOUT_CYCLES cycles in REQ.
module core_pipe_exec_lsu #(
   parameter int XLEN           = 64,
   parameter int MEM_ADDR_W     = 64,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  g_clk,
   input  logic                  g_resetn,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic                  lsu_new_instr,
   input  logic                  lsu_flush,
   input  logic                  lsu_load,
   input  logic                  lsu_store,
   input  logic [1:0]            lsu_width,
   input  logic                  lsu_signed,
   input  logic [XLEN-1:0]       lsu_addr,
   input  logic [XLEN-1:0]       lsu_wdata,
   output logic                  lsu_rd_wen,
   output logic [XLEN-1:0]       lsu_rd_wdata,
   output logic                  lsu_excep_align,
   output logic                  lsu_excep_bus,
   output logic                  dmem_req,
   output logic [MEM_ADDR_W-1:0] dmem_addr,
   output logic                  dmem_wen,
   output logic [7:0]            dmem_strb,
   output logic [63:0]           dmem_wdata,
   input  logic                  dmem_gnt,
   input  logic                  dmem_err,
   input  logic [63:0]           dmem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t                state_q, state_d;
   logic [MEM_ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]            strb_q, strb_d;
   logic [63:0]           wdata_q, wdata_d;
   logic                  wen_q, wen_d;
   logic                  load_q, load_d;
   logic [1:0]            width_q, width_d;
   logic                  signed_q, signed_d;
   logic [2:0]            off_q, off_d;
   logic                  discard_q, discard_d;
   logic                  err_q, err_d;
   logic                  first_q, first_d;
   logic [XLEN-1:0]       rdata_q, rdata_d;

   logic                  op;
   logic                  misaligned;
   logic [7:0]            baseMask;
   logic [63:0]           wdataRep;
   logic [63:0]           shifted;
   logic [XLEN-1:0]       loadExt;
   logic                  timeoutHit;

   assign op         = lsu_valid && (lsu_load || lsu_store);
   assign misaligned = (lsu_width == 2'd1 && lsu_addr[0])
                    || (lsu_width == 2'd2 && lsu_addr[1:0] != 2'b00)
                    || (lsu_width == 2'd3 && lsu_addr[2:0] != 3'b000);
   assign shifted    = dmem_rdata >> {off_q, 3'b000};

`ifdef LSU_REQ_TIMEOUT_EN
   localparam int CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CntW-1:0] cnt_q, cnt_d;

   assign timeoutHit = !dmem_gnt && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

   // Grant-wait counter: cleared when a request starts, counts ungranted REQ cycles
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE) begin
         cnt_d = '0;
      end else if (state_q == REQ && !dmem_gnt) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Grant-wait counter register
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeoutHit = 1'b0;
`endif

   // Byte mask and lane-replicated store data for the requested access size
   always_comb begin
      baseMask = 8'h01;
      wdataRep = {8{lsu_wdata[7:0]}};
      case (lsu_width)
         2'd1: begin baseMask = 8'h03; wdataRep = {4{lsu_wdata[15:0]}}; end
         2'd2: begin baseMask = 8'h0F; wdataRep = {2{lsu_wdata[31:0]}}; end
         2'd3: begin baseMask = 8'hFF; wdataRep = lsu_wdata[63:0];      end
         default: ;
      endcase
   end

   // Pick the addressed bytes out of the read doubleword and extend to XLEN
   always_comb begin
      loadExt = shifted;
      case (width_q)
         2'd0: loadExt = {{(XLEN-8){signed_q & shifted[7]}}, shifted[7:0]};
         2'd1: loadExt = {{(XLEN-16){signed_q & shifted[15]}}, shifted[15:0]};
         2'd2: loadExt = {{(XLEN-32){signed_q & shifted[31]}}, shifted[31:0]};
         default: loadExt = shifted;
      endcase
   end

   // Next-state logic for the access sequencer
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      strb_d    = strb_q;
      wdata_d   = wdata_q;
      wen_d     = wen_q;
      load_d    = load_q;
      width_d   = width_q;
      signed_d  = signed_q;
      off_d     = off_q;
      discard_d = discard_q;
      err_d     = err_q;
      rdata_d   = rdata_q;
      case (state_q)
         IDLE: begin
            if (op && !misaligned && !lsu_flush) begin
               state_d   = REQ;
               addr_d    = {lsu_addr[MEM_ADDR_W-1:3], 3'b000};
               strb_d    = 8'(baseMask << lsu_addr[2:0]);
               wdata_d   = wdataRep;
               wen_d     = lsu_store;
               load_d    = lsu_load && !lsu_store;
               width_d   = lsu_width;
               signed_d  = lsu_signed;
               off_d     = lsu_addr[2:0];
               discard_d = 1'b0;
               err_d     = 1'b0;
            end
         end
         REQ: begin
            discard_d = discard_q || lsu_flush;
            if (dmem_gnt) begin
               if (discard_q || lsu_flush) begin
                  state_d = IDLE;
               end else begin
                  state_d = DONE;
                  err_d   = dmem_err;
                  rdata_d = loadExt;
               end
            end else if (timeoutHit) begin
               state_d = (discard_q || lsu_flush) ? IDLE : DONE;
               err_d   = 1'b1;
            end
         end
         DONE: begin
            if (lsu_new_instr || lsu_flush) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      first_d = (state_d == DONE) && (state_q != DONE);
   end

   // Sequencer state and captured access fields
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         strb_q    <= '0;
         wdata_q   <= '0;
         wen_q     <= 1'b0;
         load_q    <= 1'b0;
         width_q   <= '0;
         signed_q  <= 1'b0;
         off_q     <= '0;
         discard_q <= 1'b0;
         err_q     <= 1'b0;
         first_q   <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         strb_q    <= strb_d;
         wdata_q   <= wdata_d;
         wen_q     <= wen_d;
         load_q    <= load_d;
         width_q   <= width_d;
         signed_q  <= signed_d;
         off_q     <= off_d;
         discard_q <= discard_d;
         err_q     <= err_d;
         first_q   <= first_d;
         rdata_q   <= rdata_d;
      end
   end

   // Bus drive, handshake and exception outputs
   always_comb begin
      dmem_req        = (state_q == REQ);
      dmem_addr       = dmem_req ? addr_q  : '0;
      dmem_wen        = dmem_req ? wen_q   : 1'b0;
      dmem_strb       = dmem_req ? strb_q  : 8'h00;
      dmem_wdata      = dmem_req ? wdata_q : 64'h0;
      lsu_excep_align = (state_q == IDLE) && op && misaligned;
      lsu_excep_bus   = (state_q == DONE) && err_q;
      lsu_rd_wen      = (state_q == DONE) && first_q && load_q && !err_q;
      lsu_rd_wdata    = rdata_q;
      lsu_ready       = 1'b0;
      case (state_q)
         IDLE:    lsu_ready = !(op && !misaligned && !lsu_flush);
         DONE:    lsu_ready = 1'b1;
         default: lsu_ready = 1'b0;
      endcase
   end

endmodule
